mersenne_factor_scheduler: RTL and testbench
============================================

Name: mersenne_factor_scheduler

Overview:
- Sequences a search for factors of 2^p-1 across NUM_CORES external trial-division workers.
- Each worker is one mersenneFactoring-style core: it takes p and d and reports whether 2^p mod d == 1, which means d divides 2^p-1.
- The block generates candidates d = 2kp+1 (k = 1..k_max) and discards any with d mod 8 not in {1,7}.
- Surviving candidates are dispatched round-robin to idle workers. Completions are collected and the smallest hit among all dispatched candidates is reported.

Parameters:
- BITWIDTH, 32, width of p, d, k and counters.
- NUM_CORES, 4, number of worker cores (≥1).
- IDX_W, $clog2(NUM_CORES) (minimum 1), width of the round-robin pointer.

Ports:
- sys_clk  in  1  single clock.
- sys_rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; latches p and k_max. Ignored while busy.
- p  in  BITWIDTH  Mersenne exponent.
- k_max  in  BITWIDTH  last k to try.
- abort  in  1  stop dispatching, drain, finish.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of search.
- found  out  1  a factor was found; held until next accepted start.
- factor  out  BITWIDTH  smallest hit d; 0 if none; held.
- exhausted  out  1  search ended by k_max or width overflow with no hit; held.
- tested  out  BITWIDTH  number of candidates dispatched; held.
- wrk_start  out  NUM_CORES  one-cycle start per worker.
- wrk_p  out  BITWIDTH  latched p, shared by all workers.
- wrk_d  out  NUM_CORES*BITWIDTH  per-worker divisor, held while that worker is busy.
- wrk_finished  in  NUM_CORES  worker idle/result valid. Level signal; may still be high in the cycle after wrk_start.
- wrk_hit  in  NUM_CORES  2^p mod d == 1; valid when wrk_finished is high.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. On sys_rst, all outputs are 0, state is IDLE, all slots are FREE, and the round-robin pointer is 0.
- Top FSM:
  - IDLE -> GEN on accepted start.
  - GEN -> DRAIN when a hit is recorded, the candidate set is exhausted, or abort is asserted.
  - DRAIN -> FIN when all slots are FREE.
  - FIN: pulse done for one cycle, then go to IDLE.
- start in IDLE: latch p and k_max; set cand = 2p+1 (BITWIDTH+1 bits), k = 1; clear found, factor, exhausted and tested.
- If p < 2 or k_max == 0: go straight to FIN with exhausted = 1 and tested = 0.
- Per-worker slot FSM: FREE -> ARMED (cycle of wrk_start) -> BUSY -> FREE.
  - ARMED ignores wrk_finished for one cycle.
  - In BUSY, wrk_finished == 1 retires the slot that cycle and samples wrk_hit.
- GEN step (each cycle, at most one candidate):
  - If cand[BITWIDTH] == 1 or k > k_max: mark exhausted-pending and go to DRAIN.
  - Else if cand[2:0] is not 3'b001 or 3'b111: skip; cand += 2p, k += 1.
  - Else if some slot is FREE: dispatch to the first FREE slot at or after the round-robin pointer (wrapping); drive wrk_d, pulse wrk_start, tested += 1; the pointer moves to the chosen index + 1, wrapping modulo NUM_CORES; cand += 2p, k += 1.
  - Else: stall; cand and k hold.
- Hit handling:
  - On retirement with wrk_hit, set found = 1 and factor = min(factor, d) (first hit loads directly).
  - If several workers retire in the same cycle, take the minimum of their d values.
  - Hits arriving during DRAIN still update the minimum, so the reported factor is the smallest among all dispatched candidates.
- A slot freed in cycle N may be dispatched in cycle N+1; there is no same-cycle reuse.
- abort has priority over dispatch in the same cycle. Abort in IDLE has no effect.
- exhausted = 1 at FIN only if exhausted-pending is set and found == 0; an aborted search reports exhausted = 0.
- Reset mid-search returns everything to reset values immediately. The bench must treat worker outputs as don't-care until the next start.

Decomposition:
- Shared package mersenne_pkg holds:
  - top-state enum (IDLE, GEN, DRAIN, FIN);
  - slot-state enum (FREE, ARMED, BUSY);
  - the constant for the mod-8 filter residues (1, 7).
- One natural sub-module, mf_rr_pick: round-robin first-free selector, NUM_CORES one-hot grant plus index from the FREE mask and the pointer.
- Candidate generator and minimum-hit tracker stay inline.

Test Plan:
- p=11, k_max=5, NUM_CORES=4, behavioural workers with latency 10 -> d=23 dispatched first, found=1, factor=23, tested ≥1, done one pulse, exhausted=0.
- p=13, k_max=10 -> dispatched d = 79, 105, 183, 209 (others filtered); found=0, exhausted=1, tested=4, factor=0.
- p=29, k_max=40, per-worker latencies such that the d=1103 hit retires before d=233 -> factor=233 (not 1103), found=1; wrk_start shows round-robin order 0,1,2,3,0….
- BITWIDTH=8, p=101, k_max=5 -> 203 filtered (mod 8 = 3), next candidate overflows -> exhausted=1, tested=0, no wrk_start.
- p=13, k_max=100, abort 3 cycles after the first dispatch -> no further wrk_start, done only after all in-flight workers finish, exhausted=0, found=0.
- sys_rst asserted while 4 workers are busy -> all outputs 0 asynchronously; a new start afterwards with p=11 yields factor=23.

Source files
------------

// File: rtl/mersenne_pkg.sv
// Shared types and constants for the Mersenne factor-search scheduler.
package mersenne_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        DRAIN,
        FIN
    } top_state_t;

    typedef enum logic [1:0] {
        FREE,
        ARMED,
        BUSY
    } slot_state_t;

    // Only d = +-1 mod 8 can divide 2^p-1 for odd prime p.
    localparam logic [2:0] RES_LO = 3'd1;
    localparam logic [2:0] RES_HI = 3'd7;

    function automatic logic res_ok(input logic [2:0] r);
        return (r == RES_LO) || (r == RES_HI);
    endfunction

endpackage

// File: rtl/mf_rr_pick.sv
// Round-robin first-free selector: first FREE slot at or after ptr, wrapping.
module mf_rr_pick #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned IDX_W     = 2
) (
    input  logic [NUM_CORES-1:0] free,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 valid_c,
    output logic [NUM_CORES-1:0] grant_c,
    output logic [IDX_W-1:0]     idx_c
);

    int unsigned j;

    // Scan from the pointer and take the first free slot.
    always_comb begin
        valid_c = 1'b0;
        grant_c = '0;
        idx_c   = '0;
        j       = 0;
        for (int unsigned off = 0; off < NUM_CORES; off++) begin
            j = (32'(ptr) + off) % NUM_CORES;
            if (!valid_c && free[j]) begin
                valid_c    = 1'b1;
                grant_c[j] = 1'b1;
                idx_c      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mersenne_factor_scheduler.sv
// Generates candidates d = 2kp+1, filters mod 8, dispatches them round-robin
// to trial-division workers and tracks the smallest reported hit.
module mersenne_factor_scheduler
    import mersenne_pkg::*;
#(
    parameter int unsigned BITWIDTH  = 32,
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          start,
    input  logic [BITWIDTH-1:0]           p,
    input  logic [BITWIDTH-1:0]           k_max,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          found,
    output logic [BITWIDTH-1:0]           factor,
    output logic                          exhausted,
    output logic [BITWIDTH-1:0]           tested,
    output logic [NUM_CORES-1:0]          wrk_start,
    output logic [BITWIDTH-1:0]           wrk_p,
    output logic [NUM_CORES*BITWIDTH-1:0] wrk_d,
    input  logic [NUM_CORES-1:0]          wrk_finished,
    input  logic [NUM_CORES-1:0]          wrk_hit
);

    // Two guard bits so the candidate cannot wrap past the overflow flag.
    localparam int unsigned CW = BITWIDTH + 2;

    top_state_t                  state_q, state_d;
    slot_state_t                 slot_q [NUM_CORES];
    slot_state_t                 slot_d [NUM_CORES];
    logic [BITWIDTH-1:0]         kmax_q, kmax_d, k_q, k_d, p_d;
    logic [CW-1:0]               cand_q, cand_d, twop_c;
    logic                        pend_q, pend_d;
    logic [IDX_W-1:0]            ptr_q, ptr_d;
    logic                        busy_d, done_d, found_d, exhausted_d;
    logic [BITWIDTH-1:0]         factor_d, tested_d;
    logic [NUM_CORES-1:0]        ws_d;
    logic [NUM_CORES*BITWIDTH-1:0] wd_d;

    logic [NUM_CORES-1:0]        free_c;
    logic                        hit_any_c;
    logic [BITWIDTH-1:0]         hit_min_c;
    logic                        pick_valid_c;
    logic [NUM_CORES-1:0]        pick_grant_c;
    logic [IDX_W-1:0]            pick_idx_c;
    logic                        cand_ovf_c;

    // Slot occupancy and minimum d among workers retiring with a hit this cycle.
    always_comb begin
        free_c    = '0;
        hit_any_c = 1'b0;
        hit_min_c = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            free_c[i] = (slot_q[i] == FREE);
            if (slot_q[i] == BUSY && wrk_finished[i] && wrk_hit[i]) begin
                if (!hit_any_c || wrk_d[i*BITWIDTH +: BITWIDTH] < hit_min_c)
                    hit_min_c = wrk_d[i*BITWIDTH +: BITWIDTH];
                hit_any_c = 1'b1;
            end
        end
    end

    mf_rr_pick #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_pick (
        .free    (free_c),
        .ptr     (ptr_q),
        .valid_c (pick_valid_c),
        .grant_c (pick_grant_c),
        .idx_c   (pick_idx_c)
    );

    assign twop_c     = CW'({wrk_p, 1'b0});
    assign cand_ovf_c = |cand_q[CW-1:BITWIDTH];

    // Next-state logic for the search FSM, slots and result registers.
    always_comb begin
        state_d     = state_q;
        p_d         = wrk_p;
        kmax_d      = kmax_q;
        cand_d      = cand_q;
        k_d         = k_q;
        pend_d      = pend_q;
        ptr_d       = ptr_q;
        found_d     = found;
        factor_d    = factor;
        exhausted_d = exhausted;
        tested_d    = tested;
        wd_d        = wrk_d;
        ws_d        = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            slot_d[i] = slot_q[i];
            case (slot_q[i])
                ARMED:   slot_d[i] = BUSY;
                BUSY:    if (wrk_finished[i]) slot_d[i] = FREE;
                default: ;
            endcase
        end

        if (hit_any_c) begin
            found_d = 1'b1;
            if (!found || hit_min_c < factor) factor_d = hit_min_c;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    p_d         = p;
                    kmax_d      = k_max;
                    cand_d      = CW'({p, 1'b0}) + CW'(1);
                    k_d         = BITWIDTH'(1);
                    found_d     = 1'b0;
                    factor_d    = '0;
                    exhausted_d = 1'b0;
                    tested_d    = '0;
                    pend_d      = 1'b0;
                    if (p < BITWIDTH'(2) || k_max == '0) begin
                        pend_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        state_d = GEN;
                    end
                end
            end
            GEN: begin
                if (abort || hit_any_c) begin
                    state_d = DRAIN;
                end else if (cand_ovf_c || k_q > kmax_q) begin
                    pend_d  = 1'b1;
                    state_d = DRAIN;
                end else if (!res_ok(cand_q[2:0])) begin
                    cand_d = cand_q + twop_c;
                    k_d    = k_q + BITWIDTH'(1);
                end else if (pick_valid_c) begin
                    ws_d               = pick_grant_c;
                    slot_d[pick_idx_c] = ARMED;
                    wd_d[32'(pick_idx_c)*BITWIDTH +: BITWIDTH] = cand_q[BITWIDTH-1:0];
                    tested_d           = tested + BITWIDTH'(1);
                    ptr_d              = (32'(pick_idx_c) == NUM_CORES - 1) ? '0
                                                                            : pick_idx_c + IDX_W'(1);
                    cand_d             = cand_q + twop_c;
                    k_d                = k_q + BITWIDTH'(1);
                end
            end
            DRAIN: begin
                if (&free_c) state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        done_d = (state_d == FIN);
        busy_d = (state_d == GEN) || (state_d == DRAIN);
        if (state_d == FIN && state_q != FIN) exhausted_d = pend_d && !found_d;
    end

    // State and output registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            kmax_q    <= '0;
            k_q       <= '0;
            cand_q    <= '0;
            pend_q    <= 1'b0;
            ptr_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            factor    <= '0;
            exhausted <= 1'b0;
            tested    <= '0;
            wrk_start <= '0;
            wrk_p     <= '0;
            wrk_d     <= '0;
            for (int i = 0; i < NUM_CORES; i++) slot_q[i] <= FREE;
        end else begin
            state_q   <= state_d;
            kmax_q    <= kmax_d;
            k_q       <= k_d;
            cand_q    <= cand_d;
            pend_q    <= pend_d;
            ptr_q     <= ptr_d;
            busy      <= busy_d;
            done      <= done_d;
            found     <= found_d;
            factor    <= factor_d;
            exhausted <= exhausted_d;
            tested    <= tested_d;
            wrk_start <= ws_d;
            wrk_p     <= p_d;
            wrk_d     <= wd_d;
            for (int i = 0; i < NUM_CORES; i++) slot_q[i] <= slot_d[i];
        end
    end

endmodule

// File: tb/tb_mersenne_factor_scheduler.sv
// Directed bench for mersenne_factor_scheduler with behavioural trial-division workers.
module tb_mersenne_factor_scheduler;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic         start = 1'b0, abort = 1'b0;
    logic [31:0]  p = '0, k_max = '0;
    logic         busy, done, found, exhausted;
    logic [31:0]  factor, tested, wrk_p;
    logic [3:0]   wrk_start, wrk_finished, wrk_hit;
    logic [127:0] wrk_d;

    logic         start8 = 1'b0;
    logic [7:0]   p8 = '0, kmax8 = '0;
    logic         busy8, done8, found8, exh8;
    logic [7:0]   factor8, tested8, wrk_p8;
    logic [1:0]   wrk_start8;
    logic [15:0]  wrk_d8;

    int n_checks = 0;
    int n_pass   = 0;
    int lat [4];
    int start_log [$];
    logic [31:0] d_log [$];
    int w8_cnt = 0;

    always #5 sys_clk = ~sys_clk;

    mersenne_factor_scheduler #(.BITWIDTH(32), .NUM_CORES(4)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .p(p), .k_max(k_max),
        .abort(abort), .busy(busy), .done(done), .found(found), .factor(factor),
        .exhausted(exhausted), .tested(tested), .wrk_start(wrk_start), .wrk_p(wrk_p),
        .wrk_d(wrk_d), .wrk_finished(wrk_finished), .wrk_hit(wrk_hit)
    );

    mersenne_factor_scheduler #(.BITWIDTH(8), .NUM_CORES(2)) dut8 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start8), .p(p8), .k_max(kmax8),
        .abort(1'b0), .busy(busy8), .done(done8), .found(found8), .factor(factor8),
        .exhausted(exh8), .tested(tested8), .wrk_start(wrk_start8), .wrk_p(wrk_p8),
        .wrk_d(wrk_d8), .wrk_finished(2'b11), .wrk_hit(2'b00)
    );

    // Worker reference: 2^pe mod d == 1.
    function automatic logic mp_hit(input logic [31:0] pe, input logic [31:0] d);
        logic [63:0] r, b, dd;
        dd = {32'd0, d};
        if (dd <= 64'd1) return 1'b0;
        r = 64'd1;
        b = 64'd2 % dd;
        for (int i = 0; i < 32; i++) begin
            if (pe[i]) r = (r * b) % dd;
            b = (b * b) % dd;
        end
        return r == 64'd1;
    endfunction

    // Behavioural workers with programmable latency.
    for (genvar gi = 0; gi < 4; gi++) begin : g_wrk
        logic fin_r, hit_r;
        int   cnt_r;
        assign wrk_finished[gi] = fin_r;
        assign wrk_hit[gi]      = hit_r;
        always @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                fin_r <= 1'b1; hit_r <= 1'b0; cnt_r <= 0;
            end else if (wrk_start[gi]) begin
                fin_r <= 1'b0;
                hit_r <= mp_hit(wrk_p, wrk_d[gi*32 +: 32]);
                cnt_r <= lat[gi];
            end else if (cnt_r != 0) begin
                cnt_r <= cnt_r - 1;
                if (cnt_r == 1) fin_r <= 1'b1;
            end
        end
    end

    // Dispatch log.
    always @(negedge sys_clk) begin
        for (int i = 0; i < 4; i++)
            if (wrk_start[i]) begin
                start_log.push_back(i);
                d_log.push_back(wrk_d[i*32 +: 32]);
            end
        if (|wrk_start8) w8_cnt = w8_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic do_start(input logic [31:0] pv, input logic [31:0] kv);
        @(posedge sys_clk); #1;
        start = 1'b1; p = pv; k_max = kv;
        @(posedge sys_clk); #1;
        start = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c = 0;
        while (done !== 1'b1 && c < budget) begin
            @(negedge sys_clk);
            c++;
        end
        check({tag, "_done_timeout"}, 64'(c < budget), 64'd1);
    endtask

    task automatic wait_starts(input string tag, input int target, input int budget);
        int c = 0;
        while (start_log.size() < target && c < budget) begin
            @(negedge sys_clk);
            c++;
        end
        check({tag, "_start_timeout"}, 64'(c < budget), 64'd1);
    endtask

    int base;

    initial begin
        for (int i = 0; i < 4; i++) lat[i] = 10;
        repeat (2) @(negedge sys_clk);
        // reset values
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_found", 64'(found), 0);
        check("rst_factor", 64'(factor), 0);
        check("rst_tested", 64'(tested), 0);
        check("rst_wrk", 64'(wrk_start == '0 && wrk_d == '0 && wrk_p == '0), 1);
        @(posedge sys_clk); #1 sys_rst = 1'b0;

        // p=29: 1103 hit retires before 233, min must be 233; round-robin order
        lat[0] = 3; lat[1] = 150; lat[2] = 3; lat[3] = 3;
        base = start_log.size();
        do_start(29, 40);
        wait_done("p29", 1000);
        check("p29_found", 64'(found), 1);
        check("p29_factor", 64'(factor), 233);
        check("p29_exh", 64'(exhausted), 0);
        check("p29_tested_min", 64'(tested >= 9), 1);
        check("p29_rr0", 64'(start_log[base+0]), 0);
        check("p29_rr1", 64'(start_log[base+1]), 1);
        check("p29_rr2", 64'(start_log[base+2]), 2);
        check("p29_rr3", 64'(start_log[base+3]), 3);
        check("p29_rr4", 64'(start_log[base+4]), 0);
        check("p29_d0", 64'(d_log[base]), 175);

        // p=11: d=23 first, both 23 and 89 hit
        for (int i = 0; i < 4; i++) lat[i] = 10;
        base = start_log.size();
        do_start(11, 5);
        check("p11_busy", 64'(busy), 1);
        wait_done("p11", 500);
        check("p11_found", 64'(found), 1);
        check("p11_factor", 64'(factor), 23);
        check("p11_exh", 64'(exhausted), 0);
        check("p11_tested", 64'(tested), 3);
        check("p11_d0", 64'(d_log[base]), 23);
        @(negedge sys_clk);
        check("p11_done_pulse", 64'(done), 0);
        check("p11_factor_held", 64'(factor), 23);

        // p=13, k_max=10: no factor, candidate list
        base = start_log.size();
        do_start(13, 10);
        wait_done("p13", 500);
        check("p13_found", 64'(found), 0);
        check("p13_factor", 64'(factor), 0);
        check("p13_exh", 64'(exhausted), 1);
        check("p13_tested", 64'(tested), 4);
        check("p13_busy_at_done", 64'(busy), 0);
        check("p13_nd", 64'(start_log.size() - base), 4);
        check("p13_d0", 64'(d_log[base+0]), 79);
        check("p13_d1", 64'(d_log[base+1]), 105);
        check("p13_d2", 64'(d_log[base+2]), 183);
        check("p13_d3", 64'(d_log[base+3]), 209);

        // degenerate inputs finish immediately
        base = start_log.size();
        do_start(1, 5);
        wait_done("p1", 5);
        check("p1_exh", 64'(exhausted), 1);
        check("p1_tested", 64'(tested), 0);
        do_start(13, 0);
        wait_done("k0", 5);
        check("k0_exh", 64'(exhausted), 1);
        check("k0_found", 64'(found), 0);
        check("degen_nostart", 64'(start_log.size() - base), 0);

        // abort in IDLE does nothing
        @(posedge sys_clk); #1 abort = 1'b1;
        @(posedge sys_clk); #1 abort = 1'b0;
        @(negedge sys_clk);
        check("idle_abort", 64'({busy, done}), 0);

        // 8-bit instance: 203 filtered, next candidate overflows
        @(posedge sys_clk); #1 start8 = 1'b1; p8 = 8'd101; kmax8 = 8'd5;
        @(posedge sys_clk); #1 start8 = 1'b0;
        begin
            int c = 0;
            while (done8 !== 1'b1 && c < 50) begin @(negedge sys_clk); c++; end
            check("w8_done_timeout", 64'(c < 50), 1);
        end
        check("w8_exh", 64'(exh8), 1);
        check("w8_tested", 64'(tested8), 0);
        check("w8_found", 64'(found8), 0);
        check("w8_nostart", 64'(w8_cnt), 0);

        // abort three cycles after first dispatch
        base = start_log.size();
        do_start(13, 100);
        wait_starts("ab", base + 1, 100);
        @(posedge sys_clk);
        @(posedge sys_clk); #1 abort = 1'b1;
        @(posedge sys_clk); #1 abort = 1'b0;
        wait_done("ab", 500);
        check("ab_wrk_idle", 64'(wrk_finished), 64'hf);
        check("ab_exh", 64'(exhausted), 0);
        check("ab_found", 64'(found), 0);
        check("ab_tested", 64'(tested), 2);
        check("ab_nstart", 64'(start_log.size() - base), 2);

        // asynchronous reset with all workers busy
        for (int i = 0; i < 4; i++) lat[i] = 50;
        base = start_log.size();
        do_start(13, 100);
        wait_starts("rs", base + 4, 100);
        check("rs_busy_before", 64'(busy), 1);
        #2 sys_rst = 1'b1;
        #1;
        check("rs_busy", 64'(busy), 0);
        check("rs_tested", 64'(tested), 0);
        check("rs_outs", 64'({done, found, exhausted, factor != 0}), 0);
        check("rs_wrk", 64'(wrk_start == '0 && wrk_d == '0 && wrk_p == '0), 1);
        @(posedge sys_clk); #1 sys_rst = 1'b0;
        for (int i = 0; i < 4; i++) lat[i] = 10;
        do_start(11, 5);
        wait_done("rs_p11", 500);
        check("rs_p11_found", 64'(found), 1);
        check("rs_p11_factor", 64'(factor), 23);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
